// File: rtl/ps2_pkg.sv
// Purpose: shared constants and types for the PS/2 receive-side APB controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    // APB register byte offsets; paddr[1:0] is not decoded
    localparam logic [3:0] PS2_DATA_OFS = 4'h0;
    localparam logic [3:0] PS2_STAT_OFS = 4'h4;
    localparam logic [3:0] PS2_CTRL_OFS = 4'h8;

    // CTRL register bit positions
    localparam int PS2_CTRL_IRQ_EN  = 0;
    localparam int PS2_CTRL_FLUSH   = 1;
    localparam int PS2_CTRL_OVF_CLR = 2;

    // 4-phase handshake with the PS/2 receiver
    typedef enum logic [1:0] {
        WAIT_REQ  = 2'd0,
        CAPTURE   = 2'd1,
        WAIT_DROP = 2'd2
    } hs_state_t;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Purpose: small synchronous FIFO holding received bytes until the CPU reads them.
// Latency: a push is visible on dout/count the cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
// Ports: clk/nreset (sync, active-low); push/pop/flush strobes; din/dout data;
//        count/full/empty status. Flush wins over push and pop.
module ps2_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // Extra MSB on each pointer separates full from empty when low bits match
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign rd_en = pop  && !empty && !flush;
    assign wr_en = push && (!full || rd_en) && !flush;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_rx_apb_ctrl.sv
// Purpose: captures bytes from a PS/2 receiver into a FIFO and serves them over APB.
// Latency: rx_receive rise to FIFO entry = SYNC_STAGES+1 pclk; irq 1 pclk behind state.
// Backpressure: none toward the receiver; bytes arriving while full are dropped (ovf).
// Ports: APB slave (psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr),
//        receiver handshake (rx_receive/rx_data in, rx_done out), level irq.
module ps2_rx_apb_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       pclk,
    input  logic       nreset,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [3:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    input  logic       rx_receive,
    input  logic [7:0] rx_data,
    output logic       rx_done,
    output logic       irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs;
    hs_state_t              hs_state;
    hs_state_t              hs_next;
    logic                   hs_req;

    logic                   access;
    logic                   sel_data;
    logic                   sel_stat;
    logic                   sel_ctrl;
    logic                   fifo_pop;
    logic                   fifo_flush;
    logic                   ovf_clr;
    logic                   ovf_set;
    logic                   ovf;
    logic                   irq_en;

    logic [7:0]             fifo_dout;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [2:0]             stat_count;
    logic                   unused_bits;

    assign unused_bits = ^{paddr[1:0], pwdata[7:3]};
    assign pready      = 1'b1;

    // rx_receive comes from the PS/2 clock domain
    always_ff @(posedge pclk) begin
        if (!nreset) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_receive};
    end
    assign rs = sync_q[SYNC_STAGES-1];

    // Handshake FSM: state register
    always_ff @(posedge pclk) begin
        if (!nreset) hs_state <= WAIT_REQ;
        else         hs_state <= hs_next;
    end

    // Handshake FSM: next state
    always_comb begin
        hs_next = hs_state;
        case (hs_state)
            WAIT_REQ:  if (rs)  hs_next = CAPTURE;
            CAPTURE:            hs_next = WAIT_DROP;
            WAIT_DROP: if (!rs) hs_next = WAIT_REQ;
            default:            hs_next = WAIT_REQ;
        endcase
    end

    // Handshake FSM: outputs. The single WAIT_REQ->CAPTURE edge is the only push.
    always_comb begin
        hs_req  = 1'b0;
        rx_done = 1'b0;
        case (hs_state)
            WAIT_REQ:  hs_req  = rs;
            CAPTURE:   rx_done = 1'b1;
            WAIT_DROP: rx_done = 1'b1;
            default: begin
                hs_req  = 1'b0;
                rx_done = 1'b0;
            end
        endcase
    end

    // APB decode
    assign access   = psel && penable;
    assign sel_data = (paddr[3:2] == PS2_DATA_OFS[3:2]);
    assign sel_stat = (paddr[3:2] == PS2_STAT_OFS[3:2]);
    assign sel_ctrl = (paddr[3:2] == PS2_CTRL_OFS[3:2]);

    assign fifo_pop   = access && !pwrite && sel_data && !fifo_empty;
    assign fifo_flush = access &&  pwrite && sel_ctrl && pwdata[PS2_CTRL_FLUSH];
    assign ovf_clr    = access &&  pwrite && sel_ctrl && pwdata[PS2_CTRL_OVF_CLR];
    assign ovf_set    = hs_req && fifo_full && !fifo_pop;

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk    (pclk),
        .nreset (nreset),
        .push   (hs_req),
        .pop    (fifo_pop),
        .flush  (fifo_flush),
        .din    (rx_data),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign stat_count = 3'(fifo_count);

    always_comb begin
        prdata  = 8'h00;
        pslverr = 1'b0;
        if (access) begin
            if (sel_data) begin
                if (pwrite || fifo_empty) pslverr = 1'b1;
                else                      prdata  = fifo_dout;
            end else if (sel_stat) begin
                if (pwrite) pslverr = 1'b1;
                else        prdata  = {ovf, fifo_full, fifo_empty, 2'b00, stat_count};
            end else if (sel_ctrl) begin
                // flush and ovf_clr are strobes and always read back as 0
                if (!pwrite) prdata = {7'b0, irq_en};
            end else begin
                pslverr = 1'b1;
            end
        end
    end

    // Set beats clear so an overflow in the same cycle as ovf_clr is not lost
    always_ff @(posedge pclk) begin
        if (!nreset) begin
            ovf    <= 1'b0;
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
            if (access && pwrite && sel_ctrl) irq_en <= pwdata[PS2_CTRL_IRQ_EN];
            irq <= irq_en && (!fifo_empty || ovf);
        end
    end

endmodule

// File: tb/tb_ps2_rx_apb_ctrl.sv
module tb_ps2_rx_apb_ctrl;

    localparam int DEPTH = 4;

    logic       pclk = 1'b0;
    logic       nreset;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [3:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic       rx_receive;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       irq;

    int checks = 0;
    int errors = 0;

    // Scoreboard: bytes the FIFO should hold, in order, plus the expected ovf bit
    logic [7:0] sb[$];
    logic       model_ovf;

    always #5 pclk = ~pclk;

    ps2_rx_apb_ctrl #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .pclk       (pclk),
        .nreset     (nreset),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .rx_receive (rx_receive),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .irq        (irq)
    );

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [7:0] d, output logic e);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        tick();
        penable = 1'b1;
        #1;
        d = prdata;
        e = pslverr;
        tick();
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_write(input logic [3:0] a, input logic [7:0] v, output logic e);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = v;
        tick();
        penable = 1'b1;
        #1;
        e = pslverr;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    function automatic logic [7:0] exp_status();
        int n = sb.size();
        return {model_ovf, (n == DEPTH), (n == 0), 2'b00, 3'(n)};
    endfunction

    // Bounded wait on rx_done; expiry is a failed comparison
    task automatic wait_done(input logic lvl, input string nm);
        int n = 0;
        while (rx_done !== lvl && n < 50) begin
            tick();
            n++;
        end
        if (rx_done !== lvl) begin
            checks++;
            errors++;
            $display("FAIL %s timeout rx_done=%b want %b", nm, rx_done, lvl);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_receive = 1'b1;
        if (sb.size() < DEPTH) sb.push_back(b);
        else                   model_ovf = 1'b1;
        wait_done(1'b1, "send_hi");
        rx_receive = 1'b0;
        wait_done(1'b0, "send_lo");
    endtask

    task automatic read_data_sb(input string nm);
        logic [7:0] d;
        logic       e;
        logic [7:0] exp;
        apb_read(4'h0, d, e);
        exp = (sb.size() > 0) ? sb.pop_front() : 8'h00;
        checks++;
        if (d !== exp || e !== 1'b0) begin
            errors++;
            $display("FAIL %s got %h err %b want %h err 0", nm, d, e, exp);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       e;
        nreset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; rx_receive = 1'b0; rx_data = '0;
        model_ovf = 1'b0;
        sb.delete();
        repeat (3) tick();
        checks++;
        if (rx_done !== 1'b0 || irq !== 1'b0 || pready !== 1'b1 ||
            prdata !== 8'h00 || pslverr !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got done=%b irq=%b rdy=%b prdata=%h err=%b want 0 0 1 00 0",
                     rx_done, irq, pready, prdata, pslverr);
        end
        nreset = 1'b1;
        tick();
        apb_read(4'h4, d, e);
        checks++;
        if (d !== 8'h20 || e !== 1'b0) begin
            errors++;
            $display("FAIL reset_status got %h err %b want 20 err 0", d, e);
        end
        apb_read(4'hC, d, e);
        checks++;
        if (d !== 8'h00 || e !== 1'b1) begin
            errors++;
            $display("FAIL bad_addr_read got %h err %b want 00 err 1", d, e);
        end
        apb_write(4'h0, 8'hFF, e);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL data_write_err got %b want 1", e);
        end
        apb_write(4'h8, 8'h01, e);
        apb_read(4'h8, d, e);
        checks++;
        if (d !== 8'h01 || e !== 1'b0) begin
            errors++;
            $display("FAIL ctrl_rw got %h err %b want 01 err 0", d, e);
        end
        apb_write(4'h8, 8'h02, e);
        apb_read(4'h8, d, e);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL ctrl_flush_reads0 got %h want 00", d);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] d;
        logic       e;
        rx_data = 8'hA5;
        rx_receive = 1'b1;
        sb.push_back(8'hA5);
        tick();
        tick();
        checks++;
        if (rx_done !== 1'b0) begin
            errors++;
            $display("FAIL done_early got %b want 0", rx_done);
        end
        tick();
        checks++;
        if (rx_done !== 1'b1) begin
            errors++;
            $display("FAIL done_at_3 got %b want 1", rx_done);
        end
        repeat (3) tick();
        checks++;
        if (rx_done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold got %b want 1", rx_done);
        end
        rx_receive = 1'b0;
        wait_done(1'b0, "single_lo");
        apb_read(4'h4, d, e);
        checks++;
        if (d !== 8'h01 || d !== exp_status()) begin
            errors++;
            $display("FAIL single_status got %h want 01", d);
        end
        read_data_sb("single_data");
        apb_read(4'h4, d, e);
        checks++;
        if (d !== 8'h20) begin
            errors++;
            $display("FAIL single_status_after got %h want 20", d);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic       e;
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        apb_read(4'h4, d, e);
        checks++;
        if (d !== 8'hC4 || d !== exp_status()) begin
            errors++;
            $display("FAIL ovf_status got %h want c4", d);
        end
        for (int i = 0; i < 4; i++) read_data_sb("ovf_data");
        apb_read(4'h0, d, e);
        checks++;
        if (d !== 8'h00 || e !== 1'b1) begin
            errors++;
            $display("FAIL empty_read got %h err %b want 00 err 1", d, e);
        end
        apb_write(4'h8, 8'h04, e);
        model_ovf = 1'b0;
        apb_read(4'h4, d, e);
        checks++;
        if (d !== 8'h20 || d !== exp_status()) begin
            errors++;
            $display("FAIL ovf_clr_status got %h want 20", d);
        end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] d;
        logic       e;
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
        // New byte's push edge is 3 edges after the rise; align the DATA access to it
        rx_data = 8'h14;
        rx_receive = 1'b1;
        tick();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0;
        tick();
        penable = 1'b1;
        #1;
        d = prdata;
        tick();
        psel = 1'b0; penable = 1'b0;
        exp = sb.pop_front();
        sb.push_back(8'h14);
        checks++;
        if (d !== exp || rx_done !== 1'b1) begin
            errors++;
            $display("FAIL pp_data got %h done %b want %h done 1", d, rx_done, exp);
        end
        rx_receive = 1'b0;
        wait_done(1'b0, "pp_lo");
        apb_read(4'h4, d, e);
        checks++;
        if (d !== 8'h44 || d !== exp_status()) begin
            errors++;
            $display("FAIL pp_status got %h want 44", d);
        end
        for (int i = 0; i < 4; i++) read_data_sb("pp_order");
    endtask

    task automatic test_irq();
        logic e;
        apb_write(4'h8, 8'h01, e);
        send_byte(8'h3C);
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set got %b want 1", irq);
        end
        read_data_sb("irq_data");
        tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear got %b want 0", irq);
        end
        apb_write(4'h8, 8'h00, e);
        send_byte(8'h5A);
        repeat (2) tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_disabled got %b want 0", irq);
        end
        read_data_sb("irq_data2");
    endtask

    task automatic test_flush();
        logic [7:0] d;
        logic       e;
        send_byte(8'h55);
        // Flush access lands on the push edge of 0x77
        rx_data = 8'h77;
        rx_receive = 1'b1;
        tick();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h8; pwdata = 8'h02;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        sb.delete();
        checks++;
        if (rx_done !== 1'b1) begin
            errors++;
            $display("FAIL flush_done got %b want 1", rx_done);
        end
        rx_receive = 1'b0;
        wait_done(1'b0, "flush_lo");
        apb_read(4'h4, d, e);
        checks++;
        if (d !== 8'h20 || d !== exp_status()) begin
            errors++;
            $display("FAIL flush_status got %h want 20", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic       e;
        rx_data = 8'h9E;
        rx_receive = 1'b1;
        wait_done(1'b1, "mid_hi");
        tick();
        nreset = 1'b0;
        tick();
        sb.delete();
        model_ovf = 1'b0;
        checks++;
        if (rx_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_done got %b want 0", rx_done);
        end
        nreset = 1'b1;
        sb.push_back(8'h9E);
        wait_done(1'b1, "recap_hi");
        rx_receive = 1'b0;
        wait_done(1'b0, "recap_lo");
        apb_read(4'h4, d, e);
        checks++;
        if (d !== 8'h01 || d !== exp_status()) begin
            errors++;
            $display("FAIL recap_status got %h want 01", d);
        end
        read_data_sb("recap_data");
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_overflow();
        test_push_pop_full();
        test_irq();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
